// File: rtl/conv_layer_seq_if.sv
// Engine-side bus of the convolution sequencer: per-layer parameters and the
// start_conv / w_done handshake with the im2col/GEMM engine.
interface conv_layer_seq_if #(
  parameter int unsigned TENSOR_W = 8,
  parameter int unsigned KERNEL_W = 4,
  parameter int unsigned CH_W     = 8,
  parameter int unsigned STRIDE_W = 3,
  parameter int unsigned KNUM_W   = 8,
  parameter int unsigned LAYER_W  = 2
) ();
  logic [TENSOR_W-1:0] tensor_size;
  logic [KERNEL_W-1:0] kernel_size;
  logic [CH_W-1:0]     channels;
  logic [STRIDE_W-1:0] stride;
  logic [KNUM_W-1:0]   kernel_nums;
  logic [LAYER_W-1:0]  layer_idx;
  logic                start_conv;
  logic                w_done;

  modport master (
    output tensor_size, kernel_size, channels, stride, kernel_nums, layer_idx, start_conv,
    input  w_done
  );

  modport slave (
    input  tensor_size, kernel_size, channels, stride, kernel_nums, layer_idx, start_conv,
    output w_done
  );
endinterface

// File: rtl/conv_layer_seq.sv
// Multi-layer convolution sequencer: walks a descriptor table, derives each
// layer's input size/channels from the previous layer and handshakes the engine.
module conv_layer_seq #(
  parameter int unsigned TENSOR_W   = 8,
  parameter int unsigned KERNEL_W   = 4,
  parameter int unsigned CH_W       = 8,
  parameter int unsigned STRIDE_W   = 3,
  parameter int unsigned KNUM_W     = 8,
  parameter int unsigned MAX_LAYERS = 4,
  localparam int unsigned LAYER_W   = $clog2(MAX_LAYERS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                conv_en,
  input  logic                abort,
  input  logic [TENSOR_W-1:0] cfg_tensor_size,
  input  logic [CH_W-1:0]     cfg_channels,
  input  logic [LAYER_W:0]    cfg_num_layers,
  input  logic                tbl_we,
  input  logic [LAYER_W-1:0]  tbl_addr,
  input  logic [KERNEL_W-1:0] tbl_kernel_size,
  input  logic [STRIDE_W-1:0] tbl_stride,
  input  logic [KNUM_W-1:0]   tbl_kernel_nums,
  conv_layer_seq_if.master    eng,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int unsigned GW = (TENSOR_W > KERNEL_W) ? TENSOR_W : KERNEL_W;
  localparam int unsigned CW = (TENSOR_W > STRIDE_W) ? TENSOR_W : STRIDE_W;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    CALC = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  state_t              state;
  logic [LAYER_W-1:0]  layer_idx;
  logic [LAYER_W:0]    num_layers;
  logic [TENSOR_W-1:0] in_size;
  logic [CH_W-1:0]     in_ch;
  logic [TENSOR_W-1:0] rem;
  logic [TENSOR_W-1:0] q;
  logic [TENSOR_W-1:0] next_size;

  logic [TENSOR_W-1:0] tensor_size_q;
  logic [KERNEL_W-1:0] kernel_size_q;
  logic [CH_W-1:0]     channels_q;
  logic [STRIDE_W-1:0] stride_q;
  logic [KNUM_W-1:0]   kernel_nums_q;
  logic                start_q;

  logic [KERNEL_W-1:0] tbl_k  [MAX_LAYERS];
  logic [STRIDE_W-1:0] tbl_s  [MAX_LAYERS];
  logic [KNUM_W-1:0]   tbl_kn [MAX_LAYERS];

  logic [KERNEL_W-1:0] d_k;
  logic [STRIDE_W-1:0] d_s;
  logic [KNUM_W-1:0]   d_kn;
  logic                geom_bad;
  logic                count_bad;
  logic                rem_ge;
  logic                last_layer;

  assign d_k  = tbl_k[layer_idx];
  assign d_s  = tbl_s[layer_idx];
  assign d_kn = tbl_kn[layer_idx];

  assign geom_bad   = (d_k == '0) || (d_s == '0) || (GW'(d_k) > GW'(in_size));
  assign count_bad  = (cfg_num_layers == '0) ||
                      (cfg_num_layers > (LAYER_W+1)'(MAX_LAYERS));
  assign rem_ge     = (CW'(rem) >= CW'(stride_q));
  assign last_layer = ({1'b0, layer_idx} == (num_layers - (LAYER_W+1)'(1)));

  assign eng.tensor_size = tensor_size_q;
  assign eng.kernel_size = kernel_size_q;
  assign eng.channels    = channels_q;
  assign eng.stride      = stride_q;
  assign eng.kernel_nums = kernel_nums_q;
  assign eng.layer_idx   = layer_idx;
  assign eng.start_conv  = start_q;

  // Sequencer FSM; the output-size division runs as repeated subtraction in CALC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      layer_idx     <= '0;
      num_layers    <= '0;
      in_size       <= '0;
      in_ch         <= '0;
      rem           <= '0;
      q             <= '0;
      next_size     <= '0;
      tensor_size_q <= '0;
      kernel_size_q <= '0;
      channels_q    <= '0;
      stride_q      <= '0;
      kernel_nums_q <= '0;
      start_q       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      for (int unsigned i = 0; i < MAX_LAYERS; i++) begin
        tbl_k[i]  <= '0;
        tbl_s[i]  <= '0;
        tbl_kn[i] <= '0;
      end
    end else if (enable) begin
      if (state == IDLE && tbl_we) begin
        tbl_k[tbl_addr]  <= tbl_kernel_size;
        tbl_s[tbl_addr]  <= tbl_stride;
        tbl_kn[tbl_addr] <= tbl_kernel_nums;
      end

      if (abort) begin
        state   <= IDLE;
        start_q <= 1'b0;
        busy    <= 1'b0;
        done    <= 1'b0;
        err     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (conv_en) begin
              busy <= 1'b1;
              if (count_bad) begin
                state <= ERR;
                err   <= 1'b1;
              end else begin
                state      <= LOAD;
                layer_idx  <= '0;
                num_layers <= cfg_num_layers;
                in_size    <= cfg_tensor_size;
                in_ch      <= cfg_channels;
              end
            end
          end
          LOAD: begin
            tensor_size_q <= in_size;
            channels_q    <= in_ch;
            kernel_size_q <= d_k;
            stride_q      <= d_s;
            kernel_nums_q <= d_kn;
            if (geom_bad) begin
              state <= ERR;
              err   <= 1'b1;
            end else begin
              state <= CALC;
              rem   <= in_size - TENSOR_W'(d_k);
              q     <= '0;
            end
          end
          CALC: begin
            if (rem_ge) begin
              rem <= rem - TENSOR_W'(stride_q);
              q   <= q + TENSOR_W'(1);
            end else begin
              next_size <= q + TENSOR_W'(1);
              start_q   <= 1'b1;
              state     <= WAIT;
            end
          end
          WAIT: begin
            if (eng.w_done) begin
              start_q <= 1'b0;
              if (last_layer) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                // Next layer consumes this layer's output geometry.
                layer_idx <= layer_idx + LAYER_W'(1);
                in_size   <= next_size;
                in_ch     <= CH_W'(kernel_nums_q);
                state     <= LOAD;
              end
            end
          end
          DONE: begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
          ERR: begin
            err   <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_layer_seq.sv
// Directed bench for conv_layer_seq: single/multi-layer runs, errors, abort,
// enable stall and ignored inputs, all against hand-computed values.
module tb_conv_layer_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       conv_en;
  logic       abort;
  logic [7:0] cfg_tensor_size;
  logic [7:0] cfg_channels;
  logic [2:0] cfg_num_layers;
  logic       tbl_we;
  logic [1:0] tbl_addr;
  logic [3:0] tbl_kernel_size;
  logic [2:0] tbl_stride;
  logic [7:0] tbl_kernel_nums;
  logic       busy;
  logic       done;
  logic       err;

  int vecs = 0;
  int errs = 0;
  int done_cnt = 0;
  int start_rise = 0;
  logic start_prev = 1'b0;

  conv_layer_seq_if #(.TENSOR_W(8), .KERNEL_W(4), .CH_W(8), .STRIDE_W(3),
                      .KNUM_W(8), .LAYER_W(2)) eng ();

  conv_layer_seq #(.TENSOR_W(8), .KERNEL_W(4), .CH_W(8), .STRIDE_W(3),
                   .KNUM_W(8), .MAX_LAYERS(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .conv_en         (conv_en),
    .abort           (abort),
    .cfg_tensor_size (cfg_tensor_size),
    .cfg_channels    (cfg_channels),
    .cfg_num_layers  (cfg_num_layers),
    .tbl_we          (tbl_we),
    .tbl_addr        (tbl_addr),
    .tbl_kernel_size (tbl_kernel_size),
    .tbl_stride      (tbl_stride),
    .tbl_kernel_nums (tbl_kernel_nums),
    .eng             (eng),
    .busy            (busy),
    .done            (done),
    .err             (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (eng.start_conv && !start_prev) start_rise++;
    start_prev = eng.start_conv;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr_desc(input int a, input int k, input int s, input int kn);
    tbl_addr        = 2'(a);
    tbl_kernel_size = 4'(k);
    tbl_stride      = 3'(s);
    tbl_kernel_nums = 8'(kn);
    tbl_we          = 1'b1;
    tick();
    tbl_we          = 1'b0;
  endtask

  // Accept conv_en, then step past LOAD so the layer-0 parameters are visible.
  task automatic start_run(input int in_sz, input int ch, input int nl);
    cfg_tensor_size = 8'(in_sz);
    cfg_channels    = 8'(ch);
    cfg_num_layers  = 3'(nl);
    conv_en         = 1'b1;
    tick();
    conv_en         = 1'b0;
    tick();
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (!eng.start_conv && n < 500) begin
      tick();
      n++;
    end
  endtask

  task automatic pulse_wdone;
    eng.w_done = 1'b1;
    tick();
    eng.w_done = 1'b0;
  endtask

  task automatic test_reset;
    logic [50:0] outs;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    outs = {eng.tensor_size, eng.kernel_size, eng.channels, eng.stride, eng.kernel_nums,
            eng.layer_idx, eng.start_conv, busy, done, err};
    vecs++;
    if (outs !== 51'd0) begin
      errs++;
      $display("FAIL reset_outputs got %h exp 0", outs);
    end
    // Cleared table means kernel_size 0, a geometry error on layer 0.
    start_run(8, 3, 1);
    vecs++;
    if ({err, busy, eng.kernel_size} !== {1'b1, 1'b1, 4'd0}) begin
      errs++;
      $display("FAIL reset_table_err got err=%b busy=%b k=%0d exp err=1 busy=1 k=0",
               err, busy, eng.kernel_size);
    end
    tick();
    vecs++;
    if ({err, busy} !== 2'b00) begin
      errs++;
      $display("FAIL reset_err_clear got err=%b busy=%b exp 0 0", err, busy);
    end
  endtask

  task automatic test_single_layer;
    int n;
    int d0;
    wr_desc(0, 3, 1, 16);
    start_run(8, 3, 1);
    vecs++;
    if ({eng.tensor_size, eng.kernel_size, eng.channels, eng.stride, eng.kernel_nums} !==
        {8'd8, 4'd3, 8'd3, 3'd1, 8'd16}) begin
      errs++;
      $display("FAIL single_params got %0d/%0d/%0d/%0d/%0d exp 8/3/3/1/16", eng.tensor_size,
               eng.kernel_size, eng.channels, eng.stride, eng.kernel_nums);
    end
    vecs++;
    if ({eng.layer_idx, busy, eng.start_conv} !== {2'd0, 1'b1, 1'b0}) begin
      errs++;
      $display("FAIL single_state got idx=%0d busy=%b start=%b exp 0 1 0",
               eng.layer_idx, busy, eng.start_conv);
    end
    wait_start(n);
    vecs++;
    if (n != 6) begin
      errs++;
      $display("FAIL single_calc_cycles got %0d exp 6", n);
    end
    d0 = done_cnt;
    pulse_wdone();
    vecs++;
    if ({eng.start_conv, done, busy} !== 3'b011) begin
      errs++;
      $display("FAIL single_done got start=%b done=%b busy=%b exp 0 1 1",
               eng.start_conv, done, busy);
    end
    tick();
    vecs++;
    if ({done, busy} !== 2'b00 || done_cnt != d0 + 1) begin
      errs++;
      $display("FAIL single_idle got done=%b busy=%b pulses=%0d exp 0 0 1",
               done, busy, done_cnt - d0);
    end
  endtask

  task automatic test_multi_layer;
    int exp_ts [3] = '{32, 30, 14};
    int exp_ch [3] = '{3, 8, 16};
    int exp_k  [3] = '{3, 3, 2};
    int exp_n  [3] = '{30, 14, 7};
    int n;
    int d0;
    wr_desc(0, 3, 1, 8);
    wr_desc(1, 3, 2, 16);
    wr_desc(2, 2, 2, 4);
    d0 = done_cnt;
    start_run(32, 3, 3);
    for (int l = 0; l < 3; l++) begin
      if (l > 0) tick();
      vecs++;
      if ({eng.tensor_size, eng.channels, eng.kernel_size, eng.layer_idx} !==
          {8'(exp_ts[l]), 8'(exp_ch[l]), 4'(exp_k[l]), 2'(l)}) begin
        errs++;
        $display("FAIL multi_params_l%0d got ts=%0d ch=%0d k=%0d idx=%0d exp %0d %0d %0d %0d",
                 l, eng.tensor_size, eng.channels, eng.kernel_size, eng.layer_idx,
                 exp_ts[l], exp_ch[l], exp_k[l], l);
      end
      wait_start(n);
      vecs++;
      if (n != exp_n[l]) begin
        errs++;
        $display("FAIL multi_calc_l%0d got %0d exp %0d", l, n, exp_n[l]);
      end
      pulse_wdone();
    end
    vecs++;
    if (done !== 1'b1) begin
      errs++;
      $display("FAIL multi_done got %b exp 1", done);
    end
    tick();
    vecs++;
    if (done_cnt != d0 + 1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL multi_done_count got %0d busy=%b exp 1 busy=0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_errors;
    int n;
    int sr;
    sr = start_rise;
    cfg_num_layers = 3'd0;
    conv_en = 1'b1;
    tick();
    conv_en = 1'b0;
    vecs++;
    if ({err, eng.start_conv} !== 2'b10) begin
      errs++;
      $display("FAIL err_count0 got err=%b start=%b exp 1 0", err, eng.start_conv);
    end
    tick();
    cfg_num_layers = 3'd5;
    conv_en = 1'b1;
    tick();
    conv_en = 1'b0;
    vecs++;
    if (err !== 1'b1) begin
      errs++;
      $display("FAIL err_count5 got %b exp 1", err);
    end
    tick();
    vecs++;
    if ({err, busy} !== 2'b00 || start_rise != sr) begin
      errs++;
      $display("FAIL err_count_idle got err=%b busy=%b starts=%0d exp 0 0 0",
               err, busy, start_rise - sr);
    end
    // Layer 0 yields 4, layer 1 kernel 5 does not fit.
    wr_desc(0, 3, 1, 2);
    wr_desc(1, 5, 1, 2);
    start_run(6, 3, 2);
    wait_start(n);
    vecs++;
    if (n != 4) begin
      errs++;
      $display("FAIL err_geom_l0_calc got %0d exp 4", n);
    end
    pulse_wdone();
    sr = start_rise;
    tick();
    vecs++;
    if ({err, eng.layer_idx, eng.start_conv} !== {1'b1, 2'd1, 1'b0}) begin
      errs++;
      $display("FAIL err_geom got err=%b idx=%0d start=%b exp 1 1 0",
               err, eng.layer_idx, eng.start_conv);
    end
    tick();
    vecs++;
    if ({err, busy} !== 2'b00 || start_rise != sr) begin
      errs++;
      $display("FAIL err_geom_idle got err=%b busy=%b starts=%0d exp 0 0 0",
               err, busy, start_rise - sr);
    end
  endtask

  task automatic test_abort;
    int n;
    int d0;
    wr_desc(0, 3, 1, 8);
    wr_desc(1, 3, 2, 16);
    wr_desc(2, 2, 2, 4);
    start_run(32, 3, 3);
    wait_start(n);
    pulse_wdone();
    tick();
    wait_start(n);
    d0 = done_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vecs++;
    if ({busy, eng.start_conv, done, eng.layer_idx, eng.tensor_size} !==
        {1'b0, 1'b0, 1'b0, 2'd1, 8'd30}) begin
      errs++;
      $display("FAIL abort_state got busy=%b start=%b done=%b idx=%0d ts=%0d exp 0 0 0 1 30",
               busy, eng.start_conv, done, eng.layer_idx, eng.tensor_size);
    end
    tick();
    vecs++;
    if (done_cnt != d0) begin
      errs++;
      $display("FAIL abort_no_done got %0d exp 0", done_cnt - d0);
    end
    start_run(32, 3, 3);
    vecs++;
    if ({eng.layer_idx, eng.tensor_size, eng.channels} !== {2'd0, 8'd32, 8'd3}) begin
      errs++;
      $display("FAIL abort_restart got idx=%0d ts=%0d ch=%0d exp 0 32 3",
               eng.layer_idx, eng.tensor_size, eng.channels);
    end
    for (int l = 0; l < 3; l++) begin
      if (l > 0) tick();
      wait_start(n);
      pulse_wdone();
    end
    tick();
    vecs++;
    if (done_cnt != d0 + 1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL abort_rerun_done got %0d busy=%b exp 1 0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_enable_hold;
    int n;
    wr_desc(0, 3, 1, 5);
    start_run(16, 1, 1);
    tick();
    tick();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    vecs++;
    if ({busy, eng.start_conv, eng.tensor_size, eng.kernel_nums} !==
        {1'b1, 1'b0, 8'd16, 8'd5}) begin
      errs++;
      $display("FAIL enable_frozen got busy=%b start=%b ts=%0d kn=%0d exp 1 0 16 5",
               busy, eng.start_conv, eng.tensor_size, eng.kernel_nums);
    end
    enable = 1'b1;
    wait_start(n);
    vecs++;
    if (n != 12) begin
      errs++;
      $display("FAIL enable_calc_remaining got %0d exp 12", n);
    end
    pulse_wdone();
    tick();
  endtask

  task automatic test_ignored;
    int n;
    wr_desc(0, 3, 1, 16);
    start_run(8, 3, 1);
    tbl_addr        = 2'd0;
    tbl_kernel_size = 4'd7;
    tbl_stride      = 3'd3;
    tbl_kernel_nums = 8'd99;
    tbl_we          = 1'b1;
    conv_en         = 1'b1;
    eng.w_done      = 1'b1;
    tick();
    tbl_we     = 1'b0;
    conv_en    = 1'b0;
    eng.w_done = 1'b0;
    vecs++;
    if ({busy, eng.start_conv, eng.kernel_size, eng.layer_idx} !== {1'b1, 1'b0, 4'd3, 2'd0}) begin
      errs++;
      $display("FAIL ignored_busy got busy=%b start=%b k=%0d idx=%0d exp 1 0 3 0",
               busy, eng.start_conv, eng.kernel_size, eng.layer_idx);
    end
    wait_start(n);
    vecs++;
    if (n != 5) begin
      errs++;
      $display("FAIL ignored_calc got %0d exp 5", n);
    end
    conv_en = 1'b1;
    tick();
    conv_en = 1'b0;
    vecs++;
    if ({eng.start_conv, busy} !== 2'b11) begin
      errs++;
      $display("FAIL ignored_conv_en_wait got start=%b busy=%b exp 1 1", eng.start_conv, busy);
    end
    pulse_wdone();
    tick();
    start_run(8, 3, 1);
    vecs++;
    if ({eng.tensor_size, eng.kernel_size, eng.channels, eng.stride, eng.kernel_nums} !==
        {8'd8, 4'd3, 8'd3, 3'd1, 8'd16}) begin
      errs++;
      $display("FAIL ignored_table got %0d/%0d/%0d/%0d/%0d exp 8/3/3/1/16", eng.tensor_size,
               eng.kernel_size, eng.channels, eng.stride, eng.kernel_nums);
    end
    wait_start(n);
    vecs++;
    if (n != 6) begin
      errs++;
      $display("FAIL ignored_rerun_calc got %0d exp 6", n);
    end
    pulse_wdone();
    tick();
  endtask

  initial begin
    rst             = 1'b1;
    enable          = 1'b1;
    conv_en         = 1'b0;
    abort           = 1'b0;
    cfg_tensor_size = '0;
    cfg_channels    = '0;
    cfg_num_layers  = '0;
    tbl_we          = 1'b0;
    tbl_addr        = '0;
    tbl_kernel_size = '0;
    tbl_stride      = '0;
    tbl_kernel_nums = '0;
    eng.w_done      = 1'b0;

    test_reset();
    test_single_layer();
    test_multi_layer();
    test_errors();
    test_abort();
    test_enable_hold();
    test_ignored();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
